// File: rtl/pipe_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_regbank_pkg
// Description : Register map offsets and bit positions shared by the pipe
//               enable register bank and its per-channel divider.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_regbank_pkg;

    // Per-channel register pair: CTRL at even offset, DIV at odd offset
    localparam int CTRL_OFS    = 0;
    localparam int DIV_OFS     = 1;
    localparam int STRIDE      = 2;

    // CTRL register bit positions
    localparam int EN_BIT      = 0;
    localparam int ONESHOT_BIT = 1;

    // STATUS follows the last channel pair
    function automatic int status_ofs(input int num_ch);
        return STRIDE * num_ch;
    endfunction

    // INFO follows STATUS
    function automatic int info_ofs(input int num_ch);
        return STRIDE * num_ch + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_enable_divider.sv
`default_nettype none
// ============================================================================
// Module      : pipe_enable_divider
// Description : One channel of programmable strobe generation. Counts 0..div
//               while enabled and emits a registered one-cycle strobe on the
//               terminal count. A restart (register write) forces the count
//               back to zero and suppresses the strobe on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_enable_divider #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 oneshot,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 restart,
    output logic                 strobe,
    output logic                 oneshot_done
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 w_terminal;

    // A restart takes precedence so the first strobe after a write lands
    // exactly div+1 cycles after the write edge.
    assign w_terminal   = en && !restart && (r_cnt == div);
    assign oneshot_done = w_terminal && oneshot;

    // Counter and registered strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= w_terminal;
            if (restart || !en || w_terminal) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_enable_regbank.sv
`default_nettype none
// ============================================================================
// Module      : pipe_enable_regbank
// Description : Bus-programmable bank of NUM_CH periodic pipe-enable strobes
//               with per-channel enable, one-shot mode, divide ratio and
//               sticky W1C done status.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_enable_regbank
    import pipe_regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int BASE_ADDR  = 'h40
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  read_error,
    output logic [NUM_CH-1:0]     pipe_enable,
    output logic                  done_irq
);

    logic [1:0]            r_ctrl [NUM_CH];
    logic [DIV_WIDTH-1:0]  r_div  [NUM_CH];
    logic [NUM_CH-1:0]     r_done;

    logic [31:0]           w_addr32;
    int                    w_ofs;
    logic [NUM_CH-1:0]     w_ctrl_wr;
    logic [NUM_CH-1:0]     w_div_wr;
    logic                  w_status_wr;
    logic [NUM_CH-1:0]     w_w1c;
    logic [NUM_CH-1:0]     w_oneshot_done;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_mapped;
    logic                  w_unused;

    // Upper write_data bits have no storage behind them
    assign w_unused = ^write_data;

    // Offset relative to the bank base; negative means below the bank
    assign w_addr32 = 32'(address);
    assign w_ofs    = int'(w_addr32) - BASE_ADDR;

    // Write decode
    always_comb begin
        w_ctrl_wr = '0;
        w_div_wr  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_ctrl_wr[ch] = write_enable && (w_ofs == STRIDE * ch + CTRL_OFS);
            w_div_wr[ch]  = write_enable && (w_ofs == STRIDE * ch + DIV_OFS);
        end
        w_status_wr = write_enable && (w_ofs == status_ofs(NUM_CH));
        w_w1c       = w_status_wr ? write_data[NUM_CH-1:0] : '0;
    end

    // Read mux; unmapped offsets return zero and flag an error
    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_ofs == STRIDE * ch + CTRL_OFS) begin
                w_rdata  = DATA_WIDTH'(r_ctrl[ch]);
                w_mapped = 1'b1;
            end
            if (w_ofs == STRIDE * ch + DIV_OFS) begin
                w_rdata  = DATA_WIDTH'(r_div[ch]);
                w_mapped = 1'b1;
            end
        end
        if (w_ofs == status_ofs(NUM_CH)) begin
            w_rdata  = DATA_WIDTH'(r_done);
            w_mapped = 1'b1;
        end
        if (w_ofs == info_ofs(NUM_CH)) begin
            w_rdata[7:0]  = 8'(NUM_CH);
            w_rdata[15:8] = 8'(DIV_WIDTH);
            w_mapped      = 1'b1;
        end
    end

    // Control storage: bus writes win over the one-shot self-clear of EN,
    // and a hardware DONE set wins over a simultaneous W1C.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_ctrl[ch] <= '0;
                r_div[ch]  <= '0;
            end
            r_done   <= '0;
            done_irq <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_ctrl_wr[ch]) begin
                    r_ctrl[ch] <= write_data[ONESHOT_BIT:EN_BIT];
                end else if (w_oneshot_done[ch]) begin
                    r_ctrl[ch][EN_BIT] <= 1'b0;
                end
                if (w_div_wr[ch]) begin
                    r_div[ch] <= write_data[DIV_WIDTH-1:0];
                end
            end
            r_done   <= (r_done & ~w_w1c) | w_oneshot_done;
            done_irq <= |r_done;
        end
    end

    // Registered read response; data holds between reads
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            read_error <= 1'b0;
        end else begin
            read_valid <= read_enable;
            read_error <= read_enable && !w_mapped;
            if (read_enable) begin
                read_data <= w_rdata;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pipe_enable_divider #(
            .DIV_WIDTH (DIV_WIDTH)
        ) u_divider (
            .clock        (clock),
            .reset        (reset),
            .en           (r_ctrl[ch][EN_BIT]),
            .oneshot      (r_ctrl[ch][ONESHOT_BIT]),
            .div          (r_div[ch]),
            .restart      (w_ctrl_wr[ch] | w_div_wr[ch]),
            .strobe       (pipe_enable[ch]),
            .oneshot_done (w_oneshot_done[ch])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_enable_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_enable_regbank
// Description : Self-checking bench for pipe_enable_regbank: timestamp-based
//               reference model compared every cycle, directed scenarios with
//               literal expectations, and a randomized bus phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_enable_regbank;

    localparam int NUM_CH = 4;
    localparam int BASE   = 'h40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  address = '0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic        read_enable = 1'b0;
    logic [31:0] read_data;
    logic        read_valid;
    logic        read_error;
    logic [3:0]  pipe_enable;
    logic        done_irq;

    int n_checks = 0;
    int n_err    = 0;

    pipe_enable_regbank #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_CH     (NUM_CH),
        .DIV_WIDTH  (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .read_error   (read_error),
        .pipe_enable  (pipe_enable),
        .done_irq     (done_irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each enabled channel strobes at an absolute edge number m_next, which
    // is rescheduled D+1 edges ahead on every strobe or register write.
    int          cyc = 0;
    logic [1:0]  m_ctrl [NUM_CH];
    int          m_div  [NUM_CH];
    int          m_next [NUM_CH];
    logic [NUM_CH-1:0] m_done = '0;
    logic [NUM_CH-1:0] m_set  = '0;
    logic [NUM_CH-1:0] e_pipe = '0;
    logic        e_irq = 1'b0, e_rvalid = 1'b0, e_rerr = 1'b0;
    logic [31:0] e_rdata = '0;
    logic [32:0] rd;
    int          ofs;
    logic        rst_ch;

    function automatic logic [32:0] model_read(input logic [7:0] a);
        int o;
        o = int'(a) - BASE;
        if (o >= 0 && o < 2 * NUM_CH) begin
            if (o % 2 == 0) return {1'b0, 30'b0, m_ctrl[o / 2]};
            else            return {1'b0, 32'(m_div[o / 2] & 'hFF)};
        end
        if (o == 2 * NUM_CH)     return {1'b0, 28'b0, m_done};
        if (o == 2 * NUM_CH + 1) return {1'b0, 32'h0000_0804};
        return {1'b1, 32'b0};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_ctrl[ch] = '0; m_div[ch] = 0; m_next[ch] = 0;
            end
            m_done = '0; e_pipe = '0; e_irq = 1'b0;
            e_rvalid = 1'b0; e_rerr = 1'b0; e_rdata = '0;
        end else begin
            cyc++;
            e_irq = |m_done;
            if (read_enable) begin
                rd = model_read(address);
                e_rvalid = 1'b1; e_rerr = rd[32]; e_rdata = rd[31:0];
            end else begin
                e_rvalid = 1'b0; e_rerr = 1'b0;
            end
            ofs = int'(address) - BASE;
            m_set = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rst_ch = write_enable && (ofs == 2 * ch || ofs == 2 * ch + 1);
                e_pipe[ch] = m_ctrl[ch][0] && !rst_ch && (cyc == m_next[ch]);
                if (e_pipe[ch]) begin
                    m_next[ch] = cyc + m_div[ch] + 1;
                    if (m_ctrl[ch][1]) begin
                        m_ctrl[ch][0] = 1'b0;
                        m_set[ch] = 1'b1;
                    end
                end
                if (rst_ch) begin
                    if (ofs == 2 * ch) m_ctrl[ch] = write_data[1:0];
                    else               m_div[ch]  = int'(write_data & 32'hFF);
                    m_next[ch] = cyc + m_div[ch] + 1;
                end
            end
            if (write_enable && ofs == 2 * NUM_CH) m_done = m_done & ~write_data[NUM_CH-1:0];
            m_done = m_done | m_set;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        check("pipe_enable", 32'(pipe_enable), 32'(e_pipe));
        check("done_irq", 32'(done_irq), 32'(e_irq));
        check("read_valid", 32'(read_valid), 32'(e_rvalid));
        check("read_error", 32'(read_error), 32'(e_rerr));
        check("read_data", read_data, e_rdata);
    end

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a; write_data = d; write_enable = 1'b1; read_enable = 1'b0;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(negedge clock);
        address = a; read_enable = 1'b1; write_enable = 1'b0;
        @(negedge clock);
        read_enable = 1'b0;
        d = read_data; err = read_error;
    endtask

    task automatic bus_rw(input logic [7:0] a, input logic [31:0] d, output logic [31:0] q);
        @(negedge clock);
        address = a; write_data = d; write_enable = 1'b1; read_enable = 1'b1;
        @(negedge clock);
        write_enable = 1'b0; read_enable = 1'b0;
        q = read_data;
    endtask

    // Samples one pipe_enable bit over n negedges starting at the current one
    task automatic sample_pipe(input int ch, input int n, output logic [31:0] pat);
        pat = '0;
        for (int k = 0; k < n; k++) begin
            if (k != 0) @(negedge clock);
            pat[k] = pipe_enable[ch];
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d, pat, acc;
        logic        err;

        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Reset state of every register
        for (int k = 0; k < 10; k++) begin
            bus_read(8'(BASE + k), d, err);
            check("reset_read", d, (k == 9) ? 32'h0000_0804 : 32'h0);
        end
        acc = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            acc = acc | 32'(pipe_enable);
        end
        check("reset_quiet", acc, 32'h0);

        // Periodic, D=3: strobes at 4 and 8 cycles after the CTRL write
        bus_write(8'(BASE + 3), 32'd3);
        bus_write(8'(BASE + 2), 32'd1);
        sample_pipe(1, 12, pat);
        check("periodic_ch1", pat, 32'h110);
        check("periodic_others", 32'(pipe_enable & 4'b1101), 32'h0);
        bus_write(8'(BASE + 2), 32'd0);

        // D=0 constant strobe, then DIV rewrite to 2
        bus_write(8'(BASE + 1), 32'd0);
        bus_write(8'(BASE + 0), 32'd1);
        sample_pipe(0, 6, pat);
        check("div0_const", pat, 32'h3E);
        bus_write(8'(BASE + 1), 32'd2);
        sample_pipe(0, 7, pat);
        check("div0_rewrite", pat, 32'h48);
        bus_write(8'(BASE + 0), 32'd0);

        // One-shot D=5
        bus_write(8'(BASE + 5), 32'd5);
        bus_write(8'(BASE + 4), 32'd3);
        acc = '0;
        for (int k = 0; k < 12; k++) begin
            if (k != 0) @(negedge clock);
            pat[k] = pipe_enable[2];
            acc[k] = done_irq;
        end
        check("oneshot_strobe", pat & 32'hFFF, 32'h040);
        check("oneshot_irq", acc & 32'hFFF, 32'hF80);
        bus_read(8'(BASE + 4), d, err);
        check("oneshot_ctrl", d, 32'd2);
        bus_read(8'(BASE + 8), d, err);
        check("oneshot_done", d, 32'd4);

        // W1C on the set edge loses to the hardware set
        bus_write(8'(BASE + 8), 32'd4);
        bus_write(8'(BASE + 5), 32'd1);
        bus_write(8'(BASE + 4), 32'd3);
        bus_write(8'(BASE + 8), 32'd4);
        bus_read(8'(BASE + 8), d, err);
        check("w1c_set_wins", d, 32'd4);
        bus_write(8'(BASE + 8), 32'd4);
        bus_read(8'(BASE + 8), d, err);
        check("w1c_clear", d, 32'd0);

        // Bus corner cases
        bus_write(8'h47, 32'h11);
        bus_rw(8'h47, 32'h22, d);
        check("rw_old_value", d, 32'h11);
        bus_read(8'h47, d, err);
        check("rw_new_value", d, 32'h22);
        bus_read(8'hFF, d, err);
        check("unmapped_data", d, 32'h0);
        check("unmapped_err", 32'(err), 32'h1);
        bus_write(8'h49, 32'hFFFF_FFFF);
        bus_read(8'h49, d, err);
        check("info_ro", d, 32'h0000_0804);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            int sel;
            @(negedge clock);
            sel = int'($urandom_range(0, 11));
            address = (sel < 10) ? 8'(BASE + sel) : ((sel == 10) ? 8'(BASE - 1) : 8'hFF);
            write_data = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FF07);
            write_enable = ($urandom_range(0, 3) == 0);
            read_enable  = ($urandom_range(0, 1) == 0);
        end
        @(negedge clock);
        write_enable = 1'b0; read_enable = 1'b0;

        // Async reset mid-count with a read in flight
        bus_write(8'(BASE + 3), 32'd3);
        bus_write(8'(BASE + 2), 32'd1);
        repeat (2) @(negedge clock);
        address = 8'(BASE + 3); read_enable = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_read_valid", 32'(read_valid), 32'h0);
        check("arst_read_data", read_data, 32'h0);
        check("arst_read_error", 32'(read_error), 32'h0);
        check("arst_pipe", 32'(pipe_enable), 32'h0);
        check("arst_irq", 32'(done_irq), 32'h0);
        read_enable = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;
        acc = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            acc = acc | 32'(pipe_enable);
        end
        check("post_reset_quiet", acc, 32'h0);
        bus_read(8'(BASE + 2), d, err);
        check("post_reset_ctrl", d, 32'h0);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
